// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues one instruction-memory read at a time and presents the word to decode.
// Latency: request one cycle after reset release; instr_valid one cycle after the response is accepted.
// Backpressure: holds imem_req/imem_addr until imem_ready; holds instr/instr_pc in OUT while stall=1.
// Option: define FETCH_MISALIGN_TRAP_EN to trap misaligned next-PC values (FAULT state, misalign_fault flag);
//         otherwise the next PC is forced to a word boundary.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_taken,
   input  logic [31:0] pc_branch,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misalign_fault
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      OUT
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      FAULT
`endif
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_target;
   logic [31:0] pc_next;
   logic        capture;
   logic        advance;
   logic        target_misaligned;

   // Candidate next PC: redirect target or sequential successor, modulo 2^32.
   always_comb begin
      pc_target         = branch_taken ? pc_branch : (instr_pc + 32'd4);
      target_misaligned = (pc_target[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_next = pc_target;
`else
      pc_next = {pc_target[31:2], 2'b00};
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic plus the capture/advance strobes for the datapath.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            // A response is only trusted when it coincides with our own handshake.
            if (imem_ready) begin
               if (imem_rvalid) begin
                  capture   = 1'b1;
                  state_nxt = OUT;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (!stall) begin
               advance = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
               if (target_misaligned) state_nxt = FAULT;
               else                   state_nxt = REQ;
`else
               state_nxt = REQ;
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         FAULT: state_nxt = FAULT;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // PC and presented-instruction registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         instr    <= 32'h0000_0000;
         instr_pc <= RESET_PC;
      end else begin
         if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
         end
         if (advance) pc <= pc_next;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Sticky trap flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            misalign_fault <= 1'b0;
      else if (advance && target_misaligned) misalign_fault <= 1'b1;
   end
`else
   // Alignment is forced in pc_next, so the flag has no consumer here.
   logic unused_misaligned;
   assign unused_misaligned = target_misaligned;
`endif

   // Outputs are pure state decodes / flops, never combinational from inputs.
   assign imem_req    = (state == REQ);
   assign instr_valid = (state == OUT);
   assign imem_addr   = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (RESET_PC = 32'h100).
// Vectors: inputs applied at the falling edge, outputs checked 1 ns after the next rising edge.
// Followed by a reactive zero-wait memory sequence counting fetches and instr_valid pulses.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        branch_taken;
   logic [31:0] pc_branch;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_fault;
`endif

   int errors = 0;
   int checks = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .rst          (rst),
      .branch_taken (branch_taken),
      .pc_branch    (pc_branch),
      .stall        (stall),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        bt;
      logic [31:0] pcb;
      logic        st;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_instr;
      logic [31:0] e_ipc;
      logic        e_fault;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] D0 = 32'hA000_0001, D1 = 32'hA000_0002, D2 = 32'hA000_0003;
   localparam logic [31:0] D3 = 32'hA000_0004, D4 = 32'hA000_0005, D5 = 32'hA000_0006;
   localparam logic [31:0] D6 = 32'hA000_0007, D7 = 32'hA000_0008, D8 = 32'hA000_0009;
   localparam logic [31:0] BAD = 32'hDEAD_BEEF;

   task automatic v(input logic r, input logic bt, input logic [31:0] pcb, input logic st,
                    input logic rdy, input logic rv, input logic [31:0] rd,
                    input logic e_req, input logic [31:0] e_addr, input logic e_v,
                    input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_fault);
      vec_t x;
      x.rst = r; x.bt = bt; x.pcb = pcb; x.st = st; x.rdy = rdy; x.rv = rv; x.rd = rd;
      x.e_req = e_req; x.e_addr = e_addr; x.e_v = e_v; x.e_instr = e_instr;
      x.e_ipc = e_ipc; x.e_fault = e_fault;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; pc_branch = '0; stall = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

      //  rst bt pcb           st rdy rv rd    | req addr          v  instr ipc           fault
      v(1, 0, 32'h0,        0, 0, 0, 32'h0, 0, 32'h100,      0, 32'h0, 32'h100,      0); // reset
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h100,      0, 32'h0, 32'h100,      0); // IDLE->REQ
      v(0, 0, 32'h0,        0, 1, 1, D0,    0, 32'h100,      1, D0,    32'h100,      0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h104,      0, D0,    32'h100,      0);
      v(0, 0, 32'h0,        0, 1, 1, D1,    0, 32'h104,      1, D1,    32'h104,      0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h108,      0, D1,    32'h104,      0);
      v(0, 0, 32'h0,        0, 1, 1, D2,    0, 32'h108,      1, D2,    32'h108,      0);
      v(0, 1, 32'h40,       1, 0, 0, 32'h0, 0, 32'h108,      1, D2,    32'h108,      0); // stall, branch ignored
      v(0, 0, 32'h0,        1, 0, 0, 32'h0, 0, 32'h108,      1, D2,    32'h108,      0);
      v(0, 1, 32'h80,       1, 0, 0, 32'h0, 0, 32'h108,      1, D2,    32'h108,      0);
      v(0, 1, 32'h40,       0, 0, 0, 32'h0, 1, 32'h40,       0, D2,    32'h108,      0); // redirect
      v(0, 1, 32'h80,       0, 0, 1, BAD,   1, 32'h40,       0, D2,    32'h108,      0); // rvalid w/o ready ignored
      v(0, 0, 32'h0,        0, 1, 1, D3,    0, 32'h40,       1, D3,    32'h40,       0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h44,       0, D3,    32'h40,       0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h44,       0, D3,    32'h40,       0); // ready late
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h44,       0, D3,    32'h40,       0);
      v(0, 0, 32'h0,        0, 1, 0, 32'h0, 0, 32'h44,       0, D3,    32'h40,       0); // -> WAIT
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 32'h44,       0, D3,    32'h40,       0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 0, 32'h44,       0, D3,    32'h40,       0);
      v(0, 0, 32'h0,        0, 0, 1, D4,    0, 32'h44,       1, D4,    32'h44,       0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h48,       0, D4,    32'h44,       0);
      v(0, 0, 32'h0,        0, 1, 0, 32'h0, 0, 32'h48,       0, D4,    32'h44,       0); // WAIT
      v(1, 0, 32'h0,        0, 0, 0, 32'h0, 0, 32'h100,      0, 32'h0, 32'h100,      0); // reset in WAIT
      v(0, 0, 32'h0,        0, 0, 1, BAD,   1, 32'h100,      0, 32'h0, 32'h100,      0); // stale rvalid in IDLE
      v(0, 0, 32'h0,        0, 0, 1, BAD,   1, 32'h100,      0, 32'h0, 32'h100,      0); // stale rvalid in REQ
      v(0, 0, 32'h0,        0, 1, 1, D5,    0, 32'h100,      1, D5,    32'h100,      0);
`ifdef FETCH_MISALIGN_TRAP_EN
      v(0, 1, 32'h42,       0, 0, 0, 32'h0, 0, 32'h42,       0, D5,    32'h100,      1); // trap
      v(0, 0, 32'h0,        0, 1, 1, D6,    0, 32'h42,       0, D5,    32'h100,      1);
`else
      v(0, 1, 32'h42,       0, 0, 0, 32'h0, 1, 32'h40,       0, D5,    32'h100,      0); // aligned down
      v(0, 0, 32'h0,        0, 1, 1, D6,    0, 32'h40,       1, D6,    32'h40,       0);
`endif
      v(1, 0, 32'h0,        0, 0, 0, 32'h0, 0, 32'h100,      0, 32'h0, 32'h100,      0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h100,      0, 32'h0, 32'h100,      0);
      v(0, 0, 32'h0,        0, 1, 1, D7,    0, 32'h100,      1, D7,    32'h100,      0);
      v(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, D7,    32'h100,      0);
      v(0, 0, 32'h0,        0, 1, 1, D8,    0, 32'hFFFF_FFFC, 1, D8,    32'hFFFF_FFFC, 0);
      v(0, 0, 32'h0,        0, 0, 0, 32'h0, 1, 32'h0,        0, D8,    32'hFFFF_FFFC, 0); // wrap

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst          = vecs[i].rst;
         branch_taken = vecs[i].bt;
         pc_branch    = vecs[i].pcb;
         stall        = vecs[i].st;
         imem_ready   = vecs[i].rdy;
         imem_rvalid  = vecs[i].rv;
         imem_rdata   = vecs[i].rd;
         @(posedge clk);
         #1;
         chk("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].e_req});
         chk("imem_addr",   i, imem_addr,            vecs[i].e_addr);
         chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].e_v});
         chk("instr",       i, instr,                vecs[i].e_instr);
         chk("instr_pc",    i, instr_pc,             vecs[i].e_ipc);
`ifdef FETCH_MISALIGN_TRAP_EN
         chk("misalign_fault", i, {31'b0, misalign_fault}, {31'b0, vecs[i].e_fault});
`endif
      end

      // Reactive zero-wait memory: four sequential fetches from RESET_PC, one valid pulse each.
      begin
         logic [31:0] exp_addr;
         logic        prev_v;
         int          fetched;
         int          cycles;
         exp_addr = 32'h100; prev_v = 1'b0; fetched = 0; cycles = 0;
         @(negedge clk);
         rst = 1'b1; branch_taken = 1'b0; stall = 1'b0;
         imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
         @(negedge clk);
         rst = 1'b0;
         while (fetched < 4 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
            if (instr_valid) begin
               chk("seq_pulse", fetched, {31'b0, prev_v}, 32'h0);
               chk("seq_instr", fetched, instr, exp_addr ^ 32'h5A5A_0000);
               chk("seq_ipc",   fetched, instr_pc, exp_addr);
               exp_addr = exp_addr + 32'd4;
               fetched++;
            end
            if (imem_req) begin
               chk("seq_addr", fetched, imem_addr, exp_addr);
               imem_ready  = 1'b1;
               imem_rvalid = 1'b1;
               imem_rdata  = exp_addr ^ 32'h5A5A_0000;
            end
            prev_v = instr_valid;
         end
         chk("seq_fetches", 0, 32'(fetched), 32'd4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
